// File: rtl/keystream_sched_pkg.sv
// Shared constants and FSM encoding for the ChaCha20 keystream scheduler.
package keystream_sched_pkg;
  localparam int BLK_WORDS = 4;
  localparam int DEPTH     = 2 * BLK_WORDS;
  localparam int LVL_W     = $clog2(DEPTH + 1);
  localparam int BURST_GAP = 5;
  localparam int GAP_W     = $clog2(BURST_GAP);
  localparam int SER_W     = $clog2(BLK_WORDS + 1);
  localparam int CNT_W     = 32;
  localparam int NBLK_W    = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_CORE,
    S_WRITE,
    S_DRAIN
  } state_e;
endpackage

// File: rtl/keystream_sched_occupancy.sv
// FIFO occupancy tracking: words pending in the serialiser, readable level,
// and the minimum spacing between block loads.
module ks_occupancy
  import keystream_sched_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             w_en_i,
  input  logic             r_en_i,
  output logic [LVL_W-1:0] level_o,
  output logic [LVL_W-1:0] pend_o,
  output logic             space_ok_o,
  output logic             gap_zero_o
);
  logic [LVL_W-1:0] level_q, level_d, pend_q, pend_d;
  logic [SER_W-1:0] ser_q, ser_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             word_rdy;
  logic [LVL_W:0]   resv;

  // ser_q counts words of the latest block not yet handed to the read side;
  // one word becomes readable per cycle after the load.
  always_comb begin
    word_rdy = (ser_q != '0);
    ser_d    = ser_q;
    if (w_en_i)        ser_d = SER_W'(BLK_WORDS);
    else if (word_rdy) ser_d = ser_q - SER_W'(1);
    gap_d = gap_q;
    if (w_en_i)              gap_d = GAP_W'(BURST_GAP - 1);
    else if (gap_q != '0)    gap_d = gap_q - GAP_W'(1);
    pend_d  = pend_q + (w_en_i ? LVL_W'(BLK_WORDS) : '0) - LVL_W'(word_rdy);
    level_d = level_q + LVL_W'(word_rdy) - LVL_W'(r_en_i);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      level_q <= '0;
      pend_q  <= '0;
      ser_q   <= '0;
      gap_q   <= '0;
    end else begin
      level_q <= level_d;
      pend_q  <= pend_d;
      ser_q   <= ser_d;
      gap_q   <= gap_d;
    end
  end

  assign resv       = (LVL_W+1)'(level_q) + (LVL_W+1)'(pend_q) + (LVL_W+1)'(BLK_WORDS);
  assign space_ok_o = (resv <= (LVL_W+1)'(DEPTH));
  assign gap_zero_o = (gap_q == '0);
  assign level_o    = level_q;
  assign pend_o     = pend_q;
endmodule

// File: rtl/keystream_sched.sv
// Message sequencer: issues ChaCha20 block requests, loads the keystream FIFO
// and grants words to the consumer without overflow or underflow.
module keystream_sched
  import keystream_sched_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [CNT_W-1:0]  i_init_cnt,
  input  logic [NBLK_W-1:0] i_nblk,
  output logic              o_core_start,
  output logic [CNT_W-1:0]  o_core_cnt,
  input  logic              i_core_done,
  output logic              o_fifo_w_en,
  input  logic              i_req,
  output logic              o_fifo_r_en,
  output logic              o_word_vld,
  output logic [LVL_W-1:0]  o_level,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err
);
  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, core_cnt_q, core_cnt_d;
  logic [NBLK_W-1:0] blk_q, blk_d;
  logic              done_q, done_d, err_q, err_d, vld_q;
  logic              core_start, w_en, r_en, space_ok, gap_zero, ovf;
  logic [LVL_W-1:0]  level, pend;

  // Written as init+nblk > 2^32 so that an empty message never flags.
  assign ovf = ({1'b0, i_init_cnt} + (CNT_W+1)'(i_nblk)) > {1'b1, {CNT_W{1'b0}}};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    blk_d      = blk_q;
    core_cnt_d = core_cnt_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    core_start = 1'b0;
    w_en       = 1'b0;
    case (state_q)
      S_IDLE: if (i_start) begin
        cnt_d = i_init_cnt;
        blk_d = i_nblk;
        if (ovf)                 err_d   = 1'b1;
        else if (i_nblk == '0)   done_d  = 1'b1;
        else                     state_d = S_ISSUE;
      end
      S_ISSUE: if (space_ok) begin
        core_start = 1'b1;
        core_cnt_d = cnt_q;
        state_d    = S_WAIT_CORE;
      end
      S_WAIT_CORE: if (i_core_done) state_d = S_WRITE;
      S_WRITE: if (gap_zero) begin
        w_en    = 1'b1;
        cnt_d   = cnt_q + CNT_W'(1);
        blk_d   = blk_q - NBLK_W'(1);
        state_d = (blk_q == NBLK_W'(1)) ? S_DRAIN : S_ISSUE;
      end
      S_DRAIN: if (level == '0 && pend == '0) begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      core_cnt_q <= '0;
      blk_q      <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      vld_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      core_cnt_q <= core_cnt_d;
      blk_q      <= blk_d;
      done_q     <= done_d;
      err_q      <= err_d;
      vld_q      <= r_en;
    end
  end

  ks_occupancy u_occ (
    .clk_i      (i_clk),
    .rst_i      (i_rst),
    .w_en_i     (w_en),
    .r_en_i     (r_en),
    .level_o    (level),
    .pend_o     (pend),
    .space_ok_o (space_ok),
    .gap_zero_o (gap_zero)
  );

  assign r_en         = i_req && (level != '0);
  // Counter held for the core until the next request, even after it advances.
  assign o_core_cnt   = core_start ? cnt_q : core_cnt_q;
  assign o_core_start = core_start;
  assign o_fifo_w_en  = w_en;
  assign o_fifo_r_en  = r_en;
  assign o_word_vld   = vld_q;
  assign o_level      = level;
  assign o_busy       = (state_q != S_IDLE);
  assign o_done       = done_q;
  assign o_err        = err_q;
endmodule

// File: tb/tb_keystream_sched.sv
// Randomized scoreboard bench for keystream_sched with a cycle-stamped FIFO model.
module tb_keystream_sched;
  logic        i_clk = 1'b0, i_rst = 1'b1, i_start = 1'b0, i_core_done = 1'b0, i_req = 1'b0;
  logic [31:0] i_init_cnt = '0;
  logic [15:0] i_nblk = '0;
  logic        o_core_start, o_fifo_w_en, o_fifo_r_en, o_word_vld, o_busy, o_done, o_err;
  logic [31:0] o_core_cnt;
  logic [3:0]  o_level;

  keystream_sched dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_init_cnt(i_init_cnt),
    .i_nblk(i_nblk), .o_core_start(o_core_start), .o_core_cnt(o_core_cnt),
    .i_core_done(i_core_done), .o_fifo_w_en(o_fifo_w_en), .i_req(i_req),
    .o_fifo_r_en(o_fifo_r_en), .o_word_vld(o_word_vld), .o_level(o_level),
    .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
  );

  always #5 i_clk = ~i_clk;

  typedef struct { int kind; int nwords; int imm; } evt_t;  // kind 0 done, 1 err
  evt_t        evq[$];
  logic [31:0] cntq[$];
  int n_cmp = 0, n_bad = 0, cyc = 0;
  int core_lat = 0, req_mode = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Model: each loaded block makes word k visible in cycle t+2+k.
  int mlev = 0, last_w = -100, done_cyc = -100, last_start = -100, grants = 0;
  int arr[$];
  logic prev_ren = 1'b0, chk_rst = 1'b0;
  logic [31:0] last_cnt = '0;

  always @(negedge i_clk) begin
    int lev_now, pend_now;
    evt_t e;
    cyc++;
    if (i_rst) begin
      mlev = 0; arr.delete(); evq.delete(); cntq.delete();
      last_w = -100; done_cyc = -100; grants = 0; prev_ren = 1'b0; last_cnt = '0;
      chk_rst = 1'b1;
    end else begin
      if (chk_rst) begin
        chk("reset_outputs", {o_core_start, o_core_cnt, o_fifo_w_en, o_fifo_r_en, o_word_vld,
                              o_level, o_busy, o_done, o_err}, 64'd0);
        chk_rst = 1'b0;
      end
      while (arr.size() > 0 && arr[0] == cyc) begin
        void'(arr.pop_front());
        mlev++;
      end
      lev_now = mlev; pend_now = arr.size();
      chk("level", o_level, lev_now);
      chk("level_plus_pending_le_depth", lev_now + pend_now <= 8, 1);
      chk("read_grant", o_fifo_r_en, i_req && lev_now != 0);
      chk("word_vld", o_word_vld, prev_ren);
      prev_ren = o_fifo_r_en;
      if (o_fifo_r_en) begin mlev--; grants++; end
      if (i_start) last_start = cyc;
      if (i_core_done) done_cyc = cyc;
      if (o_core_start) begin
        chk("busy_at_core_start", o_busy, 1);
        chk("reservation", lev_now + pend_now + 4 <= 8, 1);
        if (cntq.size() == 0) chk("unexpected_core_start", 1, 0);
        else chk("core_cnt", o_core_cnt, cntq.pop_front());
        last_cnt = o_core_cnt;
      end else chk("core_cnt_stable", o_core_cnt, last_cnt);
      if (o_fifo_w_en) begin
        chk("w_en_timing", cyc, imax(done_cyc + 1, last_w + 5));
        last_w = cyc;
        for (int k = 0; k < 4; k++) arr.push_back(cyc + 2 + k);
      end
      if (o_done || o_err) begin
        if (evq.size() == 0) chk("unexpected_done_or_err", {o_done, o_err}, 0);
        else begin
          e = evq.pop_front();
          chk("done_vs_err", {o_done, o_err}, (e.kind == 1) ? 2'b01 : 2'b10);
          if (e.imm != 0) chk("event_latency", cyc, last_start + 1);
          if (e.kind == 0) begin
            chk("words_granted", grants, e.nwords);
            chk("level_at_done", o_level, 0);
            chk("word_vld_at_done", o_word_vld, 0);
            chk("core_starts_consumed", cntq.size(), 0);
          end else chk("busy_at_err", o_busy, 0);
          grants = 0;
        end
      end
    end
  end

  // Core model: done pulse a fixed or random number of cycles after each request.
  initial forever begin
    int lat;
    @(negedge i_clk);
    if (o_core_start === 1'b1 && i_rst === 1'b0) begin
      lat = (core_lat == 0) ? int'($urandom_range(1, 12)) : core_lat;
      repeat (lat) @(posedge i_clk);
      #1 i_core_done = 1'b1;
      @(posedge i_clk);
      #1 i_core_done = 1'b0;
    end
  end

  // Consumer: 0 idle, 1 always requesting, 2 random, 3 driven by the stimulus.
  initial forever begin
    @(posedge i_clk);
    #1;
    case (req_mode)
      0: i_req = 1'b0;
      1: i_req = 1'b1;
      2: i_req = 1'($urandom_range(0, 1));
      default: ;
    endcase
  end

  task automatic do_reset();
    @(posedge i_clk); #1 i_rst = 1'b1;
    @(posedge i_clk); #1;
    @(posedge i_clk); #1 i_rst = 1'b0;
  endtask

  task automatic raw_start(input logic [31:0] init, input int nblk);
    @(posedge i_clk); #1;
    i_start = 1'b1; i_init_cnt = init; i_nblk = nblk[15:0];
    @(posedge i_clk); #1 i_start = 1'b0;
  endtask

  task automatic start_msg(input logic [31:0] init, input int nblk);
    evt_t e;
    longint last;
    @(posedge i_clk); #1;
    i_start = 1'b1; i_init_cnt = init; i_nblk = nblk[15:0];
    last = longint'(init) + longint'(nblk) - 1;
    if (nblk > 0 && last > 64'hFFFF_FFFF) e = '{1, 0, 1};
    else if (nblk == 0) e = '{0, 0, 1};
    else begin
      e = '{0, 4 * nblk, 0};
      for (int b = 0; b < nblk; b++) cntq.push_back(init + 32'(b));
    end
    evq.push_back(e);
    @(posedge i_clk); #1 i_start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (evq.size() > 0 && n < budget) begin @(posedge i_clk); n++; end
    if (evq.size() > 0) begin
      chk("completion_timeout", evq.size(), 0);
      do_reset();
    end
    repeat (3) @(posedge i_clk);
  endtask

  initial begin
    int n;
    logic [31:0] init;
    repeat (3) @(posedge i_clk);
    #1 i_rst = 1'b0;
    repeat (2) @(posedge i_clk);

    // single block, slow core, consumer always ready
    core_lat = 10; req_mode = 1;
    start_msg(32'd1, 1); wait_idle(200);

    // consumer idle: third request must wait for space
    core_lat = 3; req_mode = 0;
    start_msg(32'd5, 3);
    repeat (60) @(posedge i_clk);
    #1;
    chk("third_start_withheld", cntq.size(), 1);
    chk("level_full", o_level, 8);
    req_mode = 1; wait_idle(300);

    // fast core: loads paced by the burst gap
    core_lat = 1; req_mode = 1;
    start_msg(32'd20, 4); wait_idle(300);

    // counter overflow rejection and the largest accepted range
    start_msg(32'hFFFF_FFFE, 3); wait_idle(50);
    start_msg(32'hFFFF_FFFE, 2); wait_idle(300);

    // empty message, and a start while busy
    start_msg(32'd7, 0); wait_idle(50);
    core_lat = 8;
    start_msg(32'd100, 2);
    repeat (3) @(posedge i_clk);
    raw_start(32'd999, 5);
    wait_idle(300);

    // reset during a FIFO load with two words readable
    req_mode = 3; core_lat = 20; i_req = 1'b0;
    start_msg(32'd50, 2);
    n = 0;
    while (o_level !== 4'd4 && n < 100) begin @(posedge i_clk); #1; n++; end
    i_req = 1'b1;
    repeat (2) @(posedge i_clk);
    #1 i_req = 1'b0;
    n = 0;
    while (!(o_fifo_w_en === 1'b1 && o_level === 4'd2) && n < 100) begin @(posedge i_clk); #1; n++; end
    chk("reset_scenario_reached", n < 100, 1);
    i_rst = 1'b1;
    @(posedge i_clk); #1 i_rst = 1'b0;
    repeat (2) @(posedge i_clk);
    req_mode = 1; core_lat = 0;
    start_msg(32'd300, 1); wait_idle(300);

    // randomized messages
    req_mode = 2; core_lat = 0;
    for (int m = 0; m < 10; m++) begin
      init = $urandom;
      if (m % 3 == 0) init = 32'hFFFF_FFFF - 32'($urandom_range(0, 6));
      start_msg(init, int'($urandom_range(0, 6)));
      wait_idle(1500);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #600000;
    n_bad++;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
